// File: rtl/reg_wb_arbiter_if.sv
// reg_wb_arbiter_if -- bundles the write-back, issue, read-hazard and
// register-file write-port signals of reg_wb_arbiter.
//
// Signals (direction as seen by the arbiter, modport slave):
//   wb0_valid/wb0_rd/wb0_data  in   requester 0 (ALU) write-back request
//   wb0_ready                  out  requester 0 accepted this cycle
//   wb1_valid/wb1_rd/wb1_data  in   requester 1 (load unit) write-back request
//   wb1_ready                  out  requester 1 accepted this cycle
//   iss_valid/iss_rd           in   issue of an instruction writing iss_rd
//   iss_ready                  out  issue accepted this cycle
//   ra/rb                      in   register file read addresses
//   hz_a/hz_b                  out  read hazard on ra/rb
//   fwd_a/fwd_b                out  operand taken from fwd_data
//   fwd_data                   out  forwarded write data
//   rf_we/rf_rw/rf_busw        out  register file write port
// modport master is the requester/consumer side.
interface reg_wb_arbiter_if;
  logic        wb0_valid;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic        wb1_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        hz_a;
  logic        hz_b;
  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] fwd_data;
  logic        rf_we;
  logic [4:0]  rf_rw;
  logic [31:0] rf_busw;

  modport master (
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
           iss_valid, iss_rd, ra, rb,
    input  wb0_ready, wb1_ready, iss_ready, hz_a, hz_b, fwd_a, fwd_b,
           fwd_data, rf_we, rf_rw, rf_busw
  );

  modport slave (
    input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
           iss_valid, iss_rd, ra, rb,
    output wb0_ready, wb1_ready, iss_ready, hz_a, hz_b, fwd_a, fwd_b,
           fwd_data, rf_we, rf_rw, rf_busw
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter -- two-requester round-robin arbiter for a single
// register-file write port, with a 32-entry busy scoreboard that gates
// issue (WAW) and flags read hazards.
//
// Ports:
//   clk   in  single clock, all state on posedge
//   rst   in  synchronous active-high reset
//   bus   reg_wb_arbiter_if.slave (see interface file for signal list)
// Parameter:
//   RR_INIT  requester preferred first after reset when both request
// Optional feature:
//   WB_BYPASS_EN  when defined, a read address matching the write in
//                 progress is forwarded from fwd_data and not flagged
//                 as a hazard.
module reg_wb_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input logic            clk,
  input logic            rst,
  reg_wb_arbiter_if.slave bus
);

  logic        ptr_q,     ptr_d;
  logic [31:0] busy_q,    busy_d;
  logic        rf_we_q,   rf_we_d;
  logic [4:0]  rf_rw_q,   rf_rw_d;
  logic [31:0] rf_busw_q, rf_busw_d;

  logic        grant0, grant1, iss_acc;
  logic        byp_a, byp_b;

  always_comb begin
    // ptr_q selects the requester that wins a two-way conflict.
    grant0 = !rst && bus.wb0_valid && (!bus.wb1_valid || !ptr_q);
    grant1 = !rst && bus.wb1_valid && (!bus.wb0_valid ||  ptr_q);
    iss_acc = !rst && bus.iss_valid &&
              (!busy_q[bus.iss_rd] || (bus.iss_rd == 5'd0));

    ptr_d = ptr_q;
    if (bus.wb0_valid && bus.wb1_valid) ptr_d = ~ptr_q;

    rf_we_d   = 1'b0;
    rf_rw_d   = rf_rw_q;
    rf_busw_d = rf_busw_q;
    if (grant0) begin
      rf_we_d   = (bus.wb0_rd != 5'd0);
      rf_rw_d   = bus.wb0_rd;
      rf_busw_d = bus.wb0_data;
    end else if (grant1) begin
      rf_we_d   = (bus.wb1_rd != 5'd0);
      rf_rw_d   = bus.wb1_rd;
      rf_busw_d = bus.wb1_data;
    end

    // Clear first so that a same-cycle issue to the same register wins.
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_rw_q] = 1'b0;
    if (iss_acc && (bus.iss_rd != 5'd0)) busy_d[bus.iss_rd] = 1'b1;

`ifdef WB_BYPASS_EN
    byp_a = rf_we_q && (rf_rw_q == bus.ra) && (bus.ra != 5'd0);
    byp_b = rf_we_q && (rf_rw_q == bus.rb) && (bus.rb != 5'd0);
`else
    byp_a = 1'b0;
    byp_b = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= RR_INIT;
      busy_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_rw_q   <= '0;
      rf_busw_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      rf_we_q   <= rf_we_d;
      rf_rw_q   <= rf_rw_d;
      rf_busw_q <= rf_busw_d;
    end
  end

  assign bus.wb0_ready = grant0;
  assign bus.wb1_ready = grant1;
  assign bus.iss_ready = iss_acc;
  assign bus.hz_a      = busy_q[bus.ra] && (bus.ra != 5'd0) && !byp_a;
  assign bus.hz_b      = busy_q[bus.rb] && (bus.rb != 5'd0) && !byp_b;
  assign bus.fwd_a     = byp_a;
  assign bus.fwd_b     = byp_b;
  assign bus.fwd_data  = rf_busw_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rw     = rf_rw_q;
  assign bus.rf_busw   = rf_busw_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter -- directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the arbiter.
module tb_reg_wb_arbiter;
  localparam bit RR = 1'b0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_wb_arbiter_if bus_if ();
  reg_wb_arbiter #(.RR_INIT(RR)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  int checks = 0;
  int failures = 0;

  // Model state: who wins a conflict, registers with a pending write,
  // and the write visible on the port this cycle.
  int          m_ptr;
  bit          m_busy [32];
  bit          m_we;
  logic [4:0]  m_rw;
  logic [31:0] m_data;
  bit          e_g0, e_g1, e_iss;

  logic o_r0, o_r1, o_iss, o_hza, o_hzb, o_fwa, o_fwb;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.wb0_valid = 1'b0; bus_if.wb0_rd = '0; bus_if.wb0_data = '0;
    bus_if.wb1_valid = 1'b0; bus_if.wb1_rd = '0; bus_if.wb1_data = '0;
    bus_if.iss_valid = 1'b0; bus_if.iss_rd = '0;
    bus_if.ra = '0; bus_if.rb = '0;
  endtask

  // One clock cycle: sample at negedge, compare against the model,
  // advance the model, return just after the next posedge.
  task automatic step();
    bit v0, v1, iv, byp_a, byp_b, e_hza, e_hzb;
    logic [4:0] rd0, rd1, ird, ra, rb;
    logic [31:0] d0, d1;
    @(negedge clk);
    o_r0 = bus_if.wb0_ready; o_r1 = bus_if.wb1_ready; o_iss = bus_if.iss_ready;
    o_hza = bus_if.hz_a; o_hzb = bus_if.hz_b; o_fwa = bus_if.fwd_a; o_fwb = bus_if.fwd_b;
    if (rst) begin
      chk_val("rst_wb0_ready", o_r0, 0);
      chk_val("rst_wb1_ready", o_r1, 0);
      chk_val("rst_iss_ready", o_iss, 0);
      e_g0 = 0; e_g1 = 0; e_iss = 0;
      m_ptr = RR;
      foreach (m_busy[i]) m_busy[i] = 0;
      m_we = 0; m_rw = '0; m_data = '0;
    end else begin
      v0 = bus_if.wb0_valid; rd0 = bus_if.wb0_rd; d0 = bus_if.wb0_data;
      v1 = bus_if.wb1_valid; rd1 = bus_if.wb1_rd; d1 = bus_if.wb1_data;
      iv = bus_if.iss_valid; ird = bus_if.iss_rd;
      ra = bus_if.ra; rb = bus_if.rb;
      e_g0 = v0 && (!v1 || m_ptr == 0);
      e_g1 = v1 && (!v0 || m_ptr == 1);
      e_iss = iv && (ird == 0 || !m_busy[ird]);
`ifdef WB_BYPASS_EN
      byp_a = m_we && m_rw == ra && ra != 0;
      byp_b = m_we && m_rw == rb && rb != 0;
`else
      byp_a = 0;
      byp_b = 0;
`endif
      e_hza = ra != 0 && m_busy[ra] && !byp_a;
      e_hzb = rb != 0 && m_busy[rb] && !byp_b;
      chk_val("wb0_ready", o_r0, e_g0);
      chk_val("wb1_ready", o_r1, e_g1);
      chk_val("iss_ready", o_iss, e_iss);
      chk_val("hz_a", o_hza, e_hza);
      chk_val("hz_b", o_hzb, e_hzb);
      chk_val("fwd_a", o_fwa, byp_a);
      chk_val("fwd_b", o_fwb, byp_b);
      chk_val("rf_we", bus_if.rf_we, m_we);
      if (m_we) begin
        chk_val("rf_rw", bus_if.rf_rw, m_rw);
        chk_val("rf_busw", bus_if.rf_busw, m_data);
        chk_val("fwd_data", bus_if.fwd_data, m_data);
      end
      if (v0 && v1) m_ptr = 1 - m_ptr;
      if (m_we) m_busy[m_rw] = 0;
      if (e_iss && ird != 0) m_busy[ird] = 1;
      if (e_g0) begin
        m_we = rd0 != 0; m_rw = rd0; m_data = d0;
      end else if (e_g1) begin
        m_we = rd1 != 0; m_rw = rd1; m_data = d1;
      end else begin
        m_we = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  bit          p0_v, p1_v, pi_v;
  logic [4:0]  p0_rd, p1_rd, pi_rd;
  logic [31:0] p0_d, p1_d;

  initial begin
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Single write from requester 0.
    bus_if.wb0_valid = 1; bus_if.wb0_rd = 5'd5; bus_if.wb0_data = 32'h12345678;
    step();
    chk_val("d031_ready", o_r0, 1);
    chk_val("d031_we", bus_if.rf_we, 1);
    chk_val("d031_rw", bus_if.rf_rw, 5);
    chk_val("d031_busw", bus_if.rf_busw, 32'h12345678);
    idle_inputs(); step();

    // Persistent two-way conflict alternates grants.
    bus_if.wb0_valid = 1; bus_if.wb0_rd = 5'd3; bus_if.wb0_data = 32'hA0A0A0A0;
    bus_if.wb1_valid = 1; bus_if.wb1_rd = 5'd4; bus_if.wb1_data = 32'hB1B1B1B1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_val("d032_g0", o_r0, (k % 2) == 0);
      chk_val("d032_g1", o_r1, (k % 2) == 1);
      chk_val("d032_rw", bus_if.rf_rw, ((k % 2) == 0) ? 3 : 4);
    end
    idle_inputs(); step();

    // Write to r0 is accepted but never reaches the port.
    bus_if.wb1_valid = 1; bus_if.wb1_rd = 5'd0; bus_if.wb1_data = 32'hFFFFFFFF;
    step();
    chk_val("d033_ready", o_r1, 1);
    chk_val("d033_we", bus_if.rf_we, 0);
    idle_inputs(); step();

    // Issue / WAW stall / hazard release.
    bus_if.iss_valid = 1; bus_if.iss_rd = 5'd7;
    step();
    chk_val("d034_iss1", o_iss, 1);
    bus_if.ra = 5'd7;
    step();
    chk_val("d034_hz", o_hza, 1);
    chk_val("d034_iss2", o_iss, 0);
    bus_if.iss_valid = 0;
    bus_if.wb0_valid = 1; bus_if.wb0_rd = 5'd7; bus_if.wb0_data = 32'h00000777;
    step();
    chk_val("d034_wb", o_r0, 1);
    bus_if.wb0_valid = 0;
    step();
`ifdef WB_BYPASS_EN
    chk_val("d034_wr_fwd", o_fwa, 1);
    chk_val("d034_wr_hz", o_hza, 0);
`else
    chk_val("d034_wr_fwd", o_fwa, 0);
    chk_val("d034_wr_hz", o_hza, 1);
`endif
    step();
    chk_val("d034_after_hz", o_hza, 0);

    // Same-cycle set and clear of r9: set wins.
    idle_inputs();
    bus_if.wb0_valid = 1; bus_if.wb0_rd = 5'd9; bus_if.wb0_data = 32'h99;
    step();
    bus_if.wb0_valid = 0;
    bus_if.iss_valid = 1; bus_if.iss_rd = 5'd9;
    step();
    chk_val("d035_iss", o_iss, 1);
    bus_if.iss_valid = 0; bus_if.ra = 5'd9;
    step();
    chk_val("d035_hz", o_hza, 1);

    // Reset while a write is in flight.
    idle_inputs();
    bus_if.iss_valid = 1; bus_if.iss_rd = 5'd6;
    step();
    bus_if.iss_valid = 0;
    bus_if.wb0_valid = 1; bus_if.wb0_rd = 5'd6; bus_if.wb0_data = 32'h66;
    step();
    chk_val("d036_acc", o_r0, 1);
    bus_if.wb0_valid = 0;
    rst = 1'b1;
    step();
    chk_val("d036_we_rst", bus_if.rf_we, 0);
    rst = 1'b0;
    bus_if.ra = 5'd6; bus_if.rb = 5'd9;
    step();
    chk_val("d036_hza", o_hza, 0);
    chk_val("d036_hzb", o_hzb, 0);
    chk_val("d036_we", bus_if.rf_we, 0);
    bus_if.wb0_valid = 1; bus_if.wb0_rd = 5'd1; bus_if.wb0_data = 32'h1;
    bus_if.wb1_valid = 1; bus_if.wb1_rd = 5'd2; bus_if.wb1_data = 32'h2;
    step();
    chk_val("d036_ptr0", o_r0, RR == 1'b0);
    chk_val("d036_ptr1", o_r1, RR == 1'b1);
    idle_inputs(); step();

    // Randomized traffic; requesters hold until the model accepts them.
    p0_v = 0; p1_v = 0; pi_v = 0;
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!p0_v && $urandom_range(0, 1) == 1) begin
        p0_v = 1; p0_rd = 5'($urandom_range(0, 7)); p0_d = $urandom;
      end
      if (!p1_v && $urandom_range(0, 1) == 1) begin
        p1_v = 1; p1_rd = 5'($urandom_range(0, 7)); p1_d = $urandom;
      end
      if (!pi_v && $urandom_range(0, 2) == 0) begin
        pi_v = 1; pi_rd = 5'($urandom_range(0, 7));
      end
      bus_if.wb0_valid = p0_v; bus_if.wb0_rd = p0_rd; bus_if.wb0_data = p0_d;
      bus_if.wb1_valid = p1_v; bus_if.wb1_rd = p1_rd; bus_if.wb1_data = p1_d;
      bus_if.iss_valid = pi_v; bus_if.iss_rd = pi_rd;
      bus_if.ra = 5'($urandom_range(0, 7));
      bus_if.rb = 5'($urandom_range(0, 7));
      step();
      if (e_g0) p0_v = 0;
      if (e_g1) p1_v = 0;
      if (e_iss) pi_v = 0;
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
